// File: rtl/hazard_ctrl.sv
// hazard_ctrl: in-flight writer scoreboard producing forwarding selects,
// load-use stalls and branch flushes for the register-stage boundary.
module hazard_ctrl #(
    parameter int ADDR_W         = 5,
    parameter int DEPTH          = 3,
    parameter int LOAD_STAGE     = 2,
    parameter int FLUSH_CYCLES   = 2,
    parameter bit HARDWIRED_ZERO = 1'b0,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       src_a_en,
    input  logic [ADDR_W-1:0]          src_a_addr,
    input  logic                       src_b_en,
    input  logic [ADDR_W-1:0]          src_b_addr,
    input  logic                       dst_en,
    input  logic [ADDR_W-1:0]          dst_addr,
    input  logic                       dst_is_load,
    input  logic                       branch_taken,
    output logic                       stall,
    output logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] fwd_a_sel,
    output logic [$clog2(DEPTH+1)-1:0] fwd_b_sel,
    output logic [$clog2(DEPTH+1)-1:0] inflight_count,
    output logic [STALL_CNT_W-1:0]     stall_count
);

    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    // Index 0 holds slot 1 (youngest), index DEPTH-1 holds slot DEPTH.
    logic [DEPTH-1:0]       valid_reg;
    logic [DEPTH-1:0]       load_reg;
    logic [ADDR_W-1:0]      addr_reg [DEPTH];
    logic [FC_W-1:0]        flush_cnt_reg;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             haz_a;
    logic             haz_b;
    logic             zero_a;
    logic             zero_b;
    logic             zero_dst;
    logic             insert;

    // Register 0 exemption only applies when the zero register is hardwired.
    assign zero_a   = HARDWIRED_ZERO && (src_a_addr == '0);
    assign zero_b   = HARDWIRED_ZERO && (src_b_addr == '0);
    assign zero_dst = HARDWIRED_ZERO && (dst_addr == '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_hit
            assign hit_a[gi] = valid_reg[gi] && (addr_reg[gi] == src_a_addr);
            assign hit_b[gi] = valid_reg[gi] && (addr_reg[gi] == src_b_addr);
        end
    endgenerate

    // Returns {hazard, sel} for the youngest matching slot. Walking from the
    // oldest slot to the youngest lets the youngest match win.
    function automatic logic [SEL_W:0] resolve(input logic [DEPTH-1:0] hit,
                                               input logic [DEPTH-1:0] is_load);
        logic [SEL_W:0] res;
        res = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                if (is_load[i] && ((i + 1) < LOAD_STAGE))
                    res = {1'b1, {SEL_W{1'b0}}};
                else
                    res = {1'b0, SEL_W'(i + 1)};
            end
        end
        return res;
    endfunction

    // Operand resolution, masked by enable, zero exemption and reset.
    always_comb begin
        {haz_a, sel_a} = resolve(hit_a, load_reg);
        {haz_b, sel_b} = resolve(hit_b, load_reg);
        if (rst || !src_a_en || zero_a) begin
            haz_a = 1'b0;
            sel_a = '0;
        end
        if (rst || !src_b_en || zero_b) begin
            haz_b = 1'b0;
            sel_b = '0;
        end
    end

    assign flush     = !rst && (branch_taken || (flush_cnt_reg != '0));
    assign stall     = !rst && issue_valid && !flush && (haz_a || haz_b);
    assign insert    = issue_valid && dst_en && !stall && !flush && !zero_dst;
    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;

    // Slot valid/kind bits: shift every cycle, new writer (or bubble) into slot 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            load_reg  <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_reg[i] <= valid_reg[i-1];
                load_reg[i]  <= load_reg[i-1];
            end
            valid_reg[0] <= insert;
            load_reg[0]  <= dst_is_load;
        end
    end

    // Slot addresses carry no reset; they are qualified by valid_reg.
    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--)
            addr_reg[i] <= addr_reg[i-1];
        addr_reg[0] <= dst_addr;
    end

    // Flush extension counter; a new taken branch reloads it.
    always_ff @(posedge clk) begin
        if (rst)
            flush_cnt_reg <= '0;
        else if (branch_taken)
            flush_cnt_reg <= FLUSH_RELOAD;
        else if (flush_cnt_reg != '0)
            flush_cnt_reg <= flush_cnt_reg - FC_W'(1);
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end

    // Number of occupied scoreboard slots.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < DEPTH; i++)
            inflight_count = inflight_count + SEL_W'(valid_reg[i]);
    end

    assign stall_count = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: drives a default and a non-default hazard_ctrl with the same
// directed and random stimulus, checking both against a per-cycle history model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, issue_valid, src_a_en, src_b_en, dst_en, dst_is_load, branch_taken;
    logic [4:0] src_a_addr, src_b_addr, dst_addr;

    logic       s0_stall, s0_flush;
    logic [1:0] s0_fa, s0_fb, s0_inf;
    logic [15:0] s0_sc;
    logic       s1_stall, s1_flush;
    logic [2:0] s1_fa, s1_fb, s1_inf;
    logic [3:0] s1_sc;

    hazard_ctrl dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .src_a_en(src_a_en), .src_a_addr(src_a_addr),
        .src_b_en(src_b_en), .src_b_addr(src_b_addr),
        .dst_en(dst_en), .dst_addr(dst_addr), .dst_is_load(dst_is_load),
        .branch_taken(branch_taken), .stall(s0_stall), .flush(s0_flush),
        .fwd_a_sel(s0_fa), .fwd_b_sel(s0_fb),
        .inflight_count(s0_inf), .stall_count(s0_sc)
    );

    hazard_ctrl #(
        .ADDR_W(5), .DEPTH(4), .LOAD_STAGE(3), .FLUSH_CYCLES(3),
        .HARDWIRED_ZERO(1'b1), .STALL_CNT_W(4)
    ) dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .src_a_en(src_a_en), .src_a_addr(src_a_addr),
        .src_b_en(src_b_en), .src_b_addr(src_b_addr),
        .dst_en(dst_en), .dst_addr(dst_addr), .dst_is_load(dst_is_load),
        .branch_taken(branch_taken), .stall(s1_stall), .flush(s1_flush),
        .fwd_a_sel(s1_fa), .fwd_b_sel(s1_fb),
        .inflight_count(s1_inf), .stall_count(s1_sc)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int max_sc1 = 0;

    // Model parameters per instance.
    int p_depth[2];
    int p_ls[2];
    int p_fc[2];
    int p_cw[2];
    bit p_hz[2];

    // History of what each instance accepted into the pipeline, by cycle.
    bit         ins_v[2][8];
    logic [4:0] ins_a[2][8];
    bit         ins_l[2][8];
    int         last_rst[2];
    int         last_br[2];
    int         stall_cnt[2];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // A writer accepted at cycle ic is still tracked if no reset came after it.
    function automatic bit live(input int i, input int ic);
        if (ic < 0 || ic <= last_rst[i]) return 1'b0;
        return ins_v[i][ic % 8];
    endfunction

    // Writer accepted k cycles ago sits in slot k; youngest match decides.
    task automatic lookup(input int i, input logic en, input logic [4:0] a,
                          output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (!en || (p_hz[i] && a == 5'd0)) return;
        for (int k = 1; k <= p_depth[i]; k++) begin
            if (live(i, cyc - k) && ins_a[i][(cyc - k) % 8] == a) begin
                if (ins_l[i][(cyc - k) % 8] && k < p_ls[i]) haz = 1'b1;
                else sel = k;
                return;
            end
        end
    endtask

    task automatic eval_inst(input int i, input int o_st, input int o_fl, input int o_fa,
                             input int o_fb, input int o_inf, input int o_sc);
        int sa, sb, inf, sc_max, sc_exp;
        bit ha, hb, fl, st, ins;
        sa = 0; sb = 0; ha = 1'b0; hb = 1'b0; fl = 1'b0; st = 1'b0;
        if (!rst) begin
            fl = branch_taken || (last_br[i] > last_rst[i] && (cyc - last_br[i]) < p_fc[i]);
            lookup(i, src_a_en, src_a_addr, sa, ha);
            lookup(i, src_b_en, src_b_addr, sb, hb);
            st = issue_valid && !fl && (ha || hb);
        end
        inf = 0;
        for (int k = 1; k <= p_depth[i]; k++)
            if (live(i, cyc - k)) inf++;
        sc_max = (1 << p_cw[i]) - 1;
        sc_exp = (stall_cnt[i] > sc_max) ? sc_max : stall_cnt[i];

        check($sformatf("d%0d_stall", i), o_st, int'(st));
        check($sformatf("d%0d_flush", i), o_fl, int'(fl));
        check($sformatf("d%0d_fwd_a", i), o_fa, sa);
        check($sformatf("d%0d_fwd_b", i), o_fb, sb);
        check($sformatf("d%0d_inflight", i), o_inf, inf);
        check($sformatf("d%0d_stall_count", i), o_sc, sc_exp);

        ins = !rst && issue_valid && dst_en && !st && !fl && !(p_hz[i] && dst_addr == 5'd0);
        ins_v[i][cyc % 8] = ins;
        ins_a[i][cyc % 8] = dst_addr;
        ins_l[i][cyc % 8] = dst_is_load;
        if (rst) begin
            last_rst[i]  = cyc;
            stall_cnt[i] = 0;
        end else begin
            if (branch_taken) last_br[i] = cyc;
            if (st) stall_cnt[i]++;
        end
    endtask

    // Apply one cycle of inputs, check both instances mid-cycle, advance.
    task automatic step(input bit r, input bit iv, input bit ae, input logic [4:0] aa,
                        input bit be, input logic [4:0] ba, input bit de,
                        input logic [4:0] da, input bit dl, input bit bt);
        rst = r; issue_valid = iv; src_a_en = ae; src_a_addr = aa;
        src_b_en = be; src_b_addr = ba; dst_en = de; dst_addr = da;
        dst_is_load = dl; branch_taken = bt;
        @(negedge clk);
        $display("cyc=%0d rst=%0b iv=%0b a=%0b/%0d b=%0b/%0d d=%0b/%0d ld=%0b bt=%0b | d0 st=%0b fl=%0b fa=%0d fb=%0d inf=%0d sc=%0d | d1 st=%0b fl=%0b fa=%0d fb=%0d inf=%0d sc=%0d",
                 cyc, r, iv, ae, aa, be, ba, de, da, dl, bt,
                 s0_stall, s0_flush, s0_fa, s0_fb, s0_inf, s0_sc,
                 s1_stall, s1_flush, s1_fa, s1_fb, s1_inf, s1_sc);
        eval_inst(0, int'(s0_stall), int'(s0_flush), int'(s0_fa), int'(s0_fb),
                  int'(s0_inf), int'(s0_sc));
        eval_inst(1, int'(s1_stall), int'(s1_flush), int'(s1_fa), int'(s1_fb),
                  int'(s1_inf), int'(s1_sc));
        if (int'(s1_sc) > max_sc1) max_sc1 = int'(s1_sc);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        p_depth = '{3, 4};
        p_ls    = '{2, 3};
        p_fc    = '{2, 3};
        p_cw    = '{16, 4};
        p_hz    = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            last_rst[i] = -1;
            last_br[i]  = -100;
            stall_cnt[i] = 0;
            for (int j = 0; j < 8; j++) begin
                ins_v[i][j] = 1'b0;
                ins_a[i][j] = 5'd0;
                ins_l[i][j] = 1'b0;
            end
        end

        rst = 1'b1; issue_valid = 1'b0; src_a_en = 1'b0; src_b_en = 1'b0;
        dst_en = 1'b0; dst_is_load = 1'b0; branch_taken = 1'b0;
        src_a_addr = 5'd0; src_b_addr = 5'd0; dst_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset masks outputs even with active inputs.
        step(1, 1, 1, 5'd3, 1, 5'd3, 1, 5'd3, 0, 1);
        // ALU chain on r3.
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 0);
        step(0, 1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 0);
        step(0, 1, 0, 5'd0, 1, 5'd3, 0, 5'd0, 0, 0);
        step(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        step(0, 0, 1, 5'd3, 1, 5'd3, 0, 5'd0, 0, 0);
        // Load-use on r5.
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 1, 0);
        repeat (3) step(0, 1, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0);
        // Multiple writers of r7.
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0);
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd8, 0, 0);
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0);
        step(0, 1, 1, 5'd7, 1, 5'd8, 0, 5'd0, 0, 0);
        // Branch with issuing writer held, then a second branch.
        repeat (3) step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0, 0);
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0, 1);
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0, 1);
        repeat (4) step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0, 0);
        // Branch together with a load-use hazard.
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd4, 1, 0);
        step(0, 1, 1, 5'd4, 0, 5'd0, 1, 5'd6, 0, 1);
        // Reset in the middle of a stall.
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 1, 0);
        step(1, 1, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0);
        step(0, 1, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0);
        // Zero register write and read.
        step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0);
        step(0, 1, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);
        // Repeated load-use to drive the narrow stall counter into saturation.
        for (int n = 0; n < 12; n++) begin
            step(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd12, 1, 0);
            repeat (3) step(0, 1, 1, 5'd12, 0, 5'd0, 0, 5'd0, 0, 0);
        end

        // Random traffic over a small register window.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
        end

        check("d1_stall_count_saturated", max_sc1, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the decode/register → function → data core pipeline.
- Keeps a DEPTH-entry scoreboard of in-flight register writers.
- Drives per-operand forwarding selects, load-use stalls, and multi-cycle flushes on taken branches.
- Sits beside the pipeline path; the path consumes its stall, flush and select outputs at the register-stage boundary.

Parameters:
ADDR_W, 5, register address width.
DEPTH, 3, number of in-flight writer slots tracked after issue (slot 1 = youngest).
LOAD_STAGE, 2, lowest slot index at which load data is forwardable (1..DEPTH).
FLUSH_CYCLES, 2, cycles flush stays asserted per taken branch (≥1).
HARDWIRED_ZERO, 0, if 1 then address 0 never creates a hazard or forward.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
issue_valid  in  1  instruction in register stage is valid and wants to advance
src_a_en  in  1  operand A read enable
src_a_addr  in  ADDR_W  operand A register
src_b_en  in  1  operand B read enable
src_b_addr  in  ADDR_W  operand B register
dst_en  in  1  issuing instruction writes a register
dst_addr  in  ADDR_W  destination register
dst_is_load  in  1  destination is written by a load
branch_taken  in  1  taken branch resolved in function stage this cycle
stall  out  1  hold PC/inst/register-stage regs; bubble into function stage
flush  out  1  invalidate inst and register stage contents
fwd_a_sel  out  $clog2(DEPTH+1)  0 = register file; k = result of slot k
fwd_b_sel  out  $clog2(DEPTH+1)  as fwd_a_sel, for operand B
inflight_count  out  $clog2(DEPTH+1)  number of valid scoreboard slots
stall_count  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high.
- Scoreboard: slots 1..DEPTH, each {valid, addr, is_load}.
- Every non-reset cycle: slot k+1 ← slot k, and slot DEPTH is retired. A retired value is readable from the register file the following cycle.
- Slot 1 ← {issue_valid & dst_en & !stall & !flush & !(HARDWIRED_ZERO & dst_addr==0), dst_addr, dst_is_load}.
- Match, per enabled operand: find the youngest valid slot k with addr == operand addr.
  - No match, operand disabled, or zero-reg exemption: sel = 0.
  - Match with is_load and k < LOAD_STAGE: hazard, sel = 0.
  - Otherwise: sel = k.
- Stall is combinational: stall = issue_valid & !flush & (hazard_a | hazard_b).
  - A stall inserts a bubble into slot 1; older slots keep shifting.
  - A load-use stall therefore lasts exactly LOAD_STAGE − k cycles.
- Flush:
  - branch_taken asserts flush combinationally in the same cycle.
  - A registered down-counter then holds flush high for FLUSH_CYCLES−1 further cycles.
  - branch_taken during an active flush reloads the counter to FLUSH_CYCLES−1.
  - flush overrides stall (stall = 0) and blocks scoreboard insertion.
  - Older slots are not cleared by a flush.
- stall_count: increments by 1 on each cycle with stall = 1, saturates at all-ones, never wraps.
- inflight_count: popcount of slot valid bits (registered state).
- Reset (rst high at an edge):
  - All slots invalid; flush counter = 0; stall_count = 0.
  - While rst is high, stall = 0, flush = 0, fwd_*_sel = 0 regardless of inputs.
  - Reset mid-stall or mid-flush abandons the operation with no residual effect.
- Simultaneous branch_taken and load-use hazard: flush = 1, stall = 0, no insertion.
- Both operands matching different slots: each select is resolved independently. Stall if either operand has a hazard.

Test Plan:
- ALU chain (defaults): cycle t issue dst r3; t+1 src_a r3 → fwd_a_sel=1, stall=0; t+2 src_b r3 → fwd_b_sel=2; t+4 → sel=0, inflight_count=0.
- Load-use (LOAD_STAGE=2): issue load r5; next cycle src_b r5 → stall=1 for exactly 1 cycle, then fwd_b_sel=2, stall_count=1.
- Multiple writers: r7 written at t and t+2; at t+3 src_a r7 → fwd_a_sel=1 (youngest), not 3.
- Branch (FLUSH_CYCLES=2): branch_taken at t with issue_valid/dst_en held → flush=1 at t,t+1, 0 at t+2. No slots inserted at t,t+1; inflight_count falls 3→2→1. Second branch_taken at t+1 → flush high through t+2.
- Reset mid-operation: rst at a stall cycle → next cycle stall=0, inflight_count=0, stall_count=0, selects 0.
- HARDWIRED_ZERO=1: dst r0 then src_a r0 → fwd_a_sel=0, inflight_count unchanged. STALL_CNT_W=4 with 20 stall cycles → stall_count=15.
